// File: rtl/vector_sequencer_pkg.sv
// Shared types and constants for the vector sequencer: FSM state encoding,
// stimulus word field positions and the capture record width.
package vector_sequencer_pkg;

    // Sequencer states; explicit encodings keep the legacy state numbering.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_FETCH   = 3'd1,
        ST_RDWAIT  = 3'd2,
        ST_SETUP   = 3'd3,
        ST_HOLD    = 3'd4,
        ST_CAPTURE = 3'd5,
        ST_DONE    = 3'd6
    } state_t;

    // Stimulus word layout {DA, DB, DUT_CLK}.
    localparam int unsigned DA_MSB  = 8;
    localparam int unsigned DA_LSB  = 5;
    localparam int unsigned DB_MSB  = 4;
    localparam int unsigned DB_LSB  = 1;
    localparam int unsigned CLK_BIT = 0;

    // Capture record {DA, DB, DUT_CLK, Q}.
    localparam int unsigned CAP_W = 13;

    // Width of the set-up/hold timer.
    localparam int unsigned TIMER_W = 16;

    // The timer flags zero on the cycle it holds 0, so a wait of N cycles
    // is realised by preloading N-1.
    function automatic logic [TIMER_W-1:0] timer_preload(input int unsigned step);
        return TIMER_W'(step - 1);
    endfunction

endpackage

// File: rtl/vector_sequencer_timer.sv
// Loadable down-counter with a zero flag; one instance is shared by the
// SETUP and HOLD phases of the vector sequencer.
module seq_step_timer
    import vector_sequencer_pkg::*;
#(
    parameter int unsigned W = TIMER_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         en,
    output logic         zero
);

    logic [W-1:0] count;

    // Load has priority; otherwise count down while enabled, stopping at 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign zero = (count == '0);

endmodule

// File: rtl/vector_sequencer.sv
// Fetches packed {DA,DB,DUT_CLK} stimulus words from a synchronous pattern
// memory, drives them to the DUT with programmable set-up/hold spacing,
// samples Q and streams {DA,DB,DUT_CLK,Q} records over a valid/ready port.
module vector_sequencer
    import vector_sequencer_pkg::*;
#(
    parameter int unsigned WIDTH  = 9,
    parameter int unsigned DEPTH  = 100,
    parameter int unsigned ADDR_W = 7,
    parameter int unsigned STEP1  = 1,
    parameter int unsigned STEP2  = 4
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              start,
    input  logic              abort,
    output logic              busy,
    output logic              done,
    output logic              mem_rd_en,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [WIDTH-1:0]  mem_rdata,
    output logic [3:0]        DA,
    output logic [3:0]        DB,
    output logic              DUT_CLK,
    input  logic [3:0]        Q,
    output logic              cap_valid,
    input  logic              cap_ready,
    output logic [CAP_W-1:0]  cap_data,
    output logic [ADDR_W-1:0] cap_index,
    output logic [ADDR_W:0]   vec_count
);

    localparam logic [ADDR_W-1:0] LAST_INDEX = ADDR_W'(DEPTH - 1);

    state_t               state;
    state_t               state_nxt;
    logic [ADDR_W-1:0]    index;
    logic [WIDTH-1:0]     vec_reg;
    logic                 timer_load;
    logic [TIMER_W-1:0]   timer_val;
    logic                 timer_en;
    logic                 timer_zero;
    logic                 xfer;

    assign xfer = cap_valid && cap_ready;

    seq_step_timer #(
        .W(TIMER_W)
    ) u_timer (
        .clk      (CLK),
        .rst_n    (RST_N),
        .load     (timer_load),
        .load_val (timer_val),
        .en       (timer_en),
        .zero     (timer_zero)
    );

    // Next-state logic; abort from any active state overrides the normal path.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (start) state_nxt = ST_FETCH;
            ST_FETCH:   state_nxt = ST_RDWAIT;
            ST_RDWAIT:  state_nxt = ST_SETUP;
            ST_SETUP:   if (timer_zero) state_nxt = ST_HOLD;
            ST_HOLD:    if (timer_zero) state_nxt = ST_CAPTURE;
            ST_CAPTURE: if (xfer) state_nxt = (index == LAST_INDEX) ? ST_DONE : ST_FETCH;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
        if ((state != ST_IDLE) && abort) begin
            state_nxt = ST_IDLE;
        end
    end

    // Timer control: preload STEP1 on the memory read, STEP2 when the
    // vector is driven; count down only in the two waiting phases.
    always_comb begin
        timer_load = 1'b0;
        timer_val  = '0;
        timer_en   = (state == ST_SETUP) || (state == ST_HOLD);
        if (state == ST_RDWAIT) begin
            timer_load = 1'b1;
            timer_val  = timer_preload(STEP1);
        end else if ((state == ST_SETUP) && timer_zero) begin
            timer_load = 1'b1;
            timer_val  = timer_preload(STEP2);
        end
    end

    // State register.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Datapath: vector fetch, DUT drive, Q capture and record hand-off.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            index     <= '0;
            vec_count <= '0;
            vec_reg   <= '0;
            DA        <= '0;
            DB        <= '0;
            DUT_CLK   <= 1'b0;
            cap_valid <= 1'b0;
            cap_data  <= '0;
            cap_index <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        index     <= '0;
                        vec_count <= '0;
                    end
                end
                ST_RDWAIT: begin
                    vec_reg <= mem_rdata;
                end
                ST_SETUP: begin
                    if (timer_zero && !abort) begin
                        DA      <= vec_reg[DA_MSB:DA_LSB];
                        DB      <= vec_reg[DB_MSB:DB_LSB];
                        DUT_CLK <= vec_reg[CLK_BIT];
                    end
                end
                ST_HOLD: begin
                    if (timer_zero && !abort) begin
                        cap_data  <= {DA, DB, DUT_CLK, Q};
                        cap_index <= index;
                        cap_valid <= 1'b1;
                    end
                end
                ST_CAPTURE: begin
                    if (abort) begin
                        cap_valid <= 1'b0;
                    end else if (xfer) begin
                        cap_valid <= 1'b0;
                        vec_count <= vec_count + 1'b1;
                        if (index != LAST_INDEX) begin
                            index <= index + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state != ST_IDLE);
    assign done      = (state == ST_DONE);
    assign mem_rd_en = (state == ST_FETCH);
    assign mem_addr  = index;

endmodule

// File: tb/tb_vector_sequencer.sv
// Self-checking bench for vector_sequencer: a default-timing instance and a
// STEP1=2/STEP2=1 instance, each fed by a pattern memory holding i mod 512.
module tb_vector_sequencer;

    typedef struct {
        logic [12:0] data;
        logic [6:0]  idx;
    } rec_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    // Instance 1: default parameters, Q = DA + DB
    logic       start1, abort1, busy1, done1, rd1, rdy1, val1, dclk1;
    logic [6:0] addr1, idx1;
    logic [8:0] rdata1;
    logic [3:0] da1, db1, q1_in;
    logic [12:0] data1;
    logic [7:0] cnt1;

    // Instance 2: STEP1=2, STEP2=1, Q = DA ^ DB
    logic       start2, abort2, busy2, done2, rd2, rdy2, val2, dclk2;
    logic [6:0] addr2, idx2;
    logic [8:0] rdata2;
    logic [3:0] da2, db2, q2_in;
    logic [12:0] data2;
    logic [7:0] cnt2;

    assign q1_in = da1 + db1;
    assign q2_in = da2 ^ db2;

    vector_sequencer dut1 (
        .CLK(clk), .RST_N(rst_n), .start(start1), .abort(abort1),
        .busy(busy1), .done(done1), .mem_rd_en(rd1), .mem_addr(addr1),
        .mem_rdata(rdata1), .DA(da1), .DB(db1), .DUT_CLK(dclk1), .Q(q1_in),
        .cap_valid(val1), .cap_ready(rdy1), .cap_data(data1),
        .cap_index(idx1), .vec_count(cnt1)
    );

    vector_sequencer #(
        .WIDTH(9), .DEPTH(100), .ADDR_W(7), .STEP1(2), .STEP2(1)
    ) dut2 (
        .CLK(clk), .RST_N(rst_n), .start(start2), .abort(abort2),
        .busy(busy2), .done(done2), .mem_rd_en(rd2), .mem_addr(addr2),
        .mem_rdata(rdata2), .DA(da2), .DB(db2), .DUT_CLK(dclk2), .Q(q2_in),
        .cap_valid(val2), .cap_ready(rdy2), .cap_data(data2),
        .cap_index(idx2), .vec_count(cnt2)
    );

    // Synchronous pattern memory, vector i = i mod 512
    logic [8:0] mem [0:127];
    initial for (int i = 0; i < 128; i++) mem[i] = 9'(i % 512);
    always @(posedge clk) begin
        if (rd1) rdata1 <= mem[addr1];
        if (rd2) rdata2 <= mem[addr2];
    end

    rec_t sb1[$];
    rec_t sb2[$];
    int   recs1, recs2, done_cnt1, done_cnt2;
    int unsigned rd2_times[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_run(input int which, input int n);
        rec_t r;
        logic [8:0] v;
        logic [3:0] a, b, qq;
        for (int k = 0; k < n; k++) begin
            v  = 9'(k % 512);
            a  = v[8:5];
            b  = v[4:1];
            qq = (which == 1) ? 4'(a + b) : (a ^ b);
            r.data = {a, b, v[0], qq};
            r.idx  = 7'(k);
            if (which == 1) sb1.push_back(r);
            else sb2.push_back(r);
        end
    endtask

    task automatic wait_done(input int which, input int limit, output int unsigned at);
        at = 0;
        for (int i = 0; i < limit; i++) begin
            if ((which == 1) ? done1 : done2) begin
                at = cyc;
                return;
            end
            @(negedge clk);
        end
        check("done_timeout", 0, 1);
    endtask

    task automatic check_zero1(input string p);
        check({p, "_busy"}, busy1, 0);
        check({p, "_done"}, done1, 0);
        check({p, "_rd_en"}, rd1, 0);
        check({p, "_addr"}, addr1, 0);
        check({p, "_da"}, da1, 0);
        check({p, "_db"}, db1, 0);
        check({p, "_dut_clk"}, dclk1, 0);
        check({p, "_cap_valid"}, val1, 0);
        check({p, "_cap_data"}, data1, 0);
        check({p, "_cap_index"}, idx1, 0);
        check({p, "_vec_count"}, cnt1, 0);
    endtask

    // Scoreboard monitor, instance 1
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (val1) begin
                if (sb1.size() == 0) begin
                    check("m1_unexpected_record", 1, 0);
                end else begin
                    check("m1_cap_data", data1, sb1[0].data);
                    check("m1_cap_index", idx1, sb1[0].idx);
                    if (rdy1) begin
                        void'(sb1.pop_front());
                        recs1++;
                    end
                end
            end
            if (done1) done_cnt1++;
        end
    end

    // Scoreboard monitor, instance 2
    always begin
        @(negedge clk);
        #1;
        if (rst_n) begin
            if (val2) begin
                if (sb2.size() == 0) begin
                    check("m2_unexpected_record", 1, 0);
                end else begin
                    check("m2_cap_data", data2, sb2[0].data);
                    check("m2_cap_index", idx2, sb2[0].idx);
                    if (rdy2) begin
                        void'(sb2.pop_front());
                        recs2++;
                    end
                end
            end
            if (done2) done_cnt2++;
            if (rd2) rd2_times.push_back(cyc);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int unsigned c0, dcyc, bad;
        logic [12:0] held;
        bit found;

        rst_n = 1'b0;
        start1 = 1'b0; abort1 = 1'b0; rdy1 = 1'b1;
        start2 = 1'b0; abort2 = 1'b0; rdy2 = 1'b1;
        recs1 = 0; recs2 = 0; done_cnt1 = 0; done_cnt2 = 0;
        repeat (2) @(negedge clk);
        check_zero1("rst");
        check("rst_busy2", busy2, 0);
        check("rst_cap_valid2", val2, 0);
        @(negedge clk);
        rst_n = 1'b1;

        // Full default run; done is seen in the 801st cycle after start
        @(negedge clk);
        push_run(1, 100);
        recs1 = 0; done_cnt1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        c0 = cyc;
        check("t1_rd_en", rd1, 1);
        check("t1_addr", addr1, 0);
        check("t1_busy", busy1, 1);
        wait_done(1, 2000, dcyc);
        check("t1_done_at", dcyc - c0, 800);
        @(negedge clk);
        check("t1_busy_after", busy1, 0);
        check("t1_done_after", done1, 0);
        check("t1_vec_count", cnt1, 100);
        check("t1_records", recs1, 100);
        check("t1_done_pulses", done_cnt1, 1);
        check("t1_sb_empty", sb1.size(), 0);

        // Consumer stall of 5 cycles on record 3
        push_run(1, 100);
        recs1 = 0; done_cnt1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        c0 = cyc;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (val1 && idx1 == 7'd3) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t2_found_rec3", found, 1);
        rdy1 = 1'b0;
        held = data1;
        repeat (5) @(negedge clk);
        check("t2_stall_valid", val1, 1);
        check("t2_stall_data", data1, held);
        check("t2_stall_index", idx1, 3);
        rdy1 = 1'b1;
        @(negedge clk);
        check("t2_next_rd_en", rd1, 1);
        check("t2_next_addr", addr1, 4);
        check("t2_valid_dropped", val1, 0);
        wait_done(1, 2000, dcyc);
        check("t2_done_at", dcyc - c0, 805);
        @(negedge clk);
        check("t2_vec_count", cnt1, 100);
        check("t2_records", recs1, 100);
        check("t2_done_pulses", done_cnt1, 1);
        check("t2_sb_empty", sb1.size(), 0);

        // Second instance: STEP1=2, STEP2=1, Q = DA^DB, 6-cycle period
        push_run(2, 100);
        recs2 = 0; done_cnt2 = 0;
        rd2_times.delete();
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        c0 = cyc;
        wait_done(2, 2000, dcyc);
        check("t3_done_at", dcyc - c0, 600);
        @(negedge clk);
        check("t3_rd_count", rd2_times.size(), 100);
        if (rd2_times.size() >= 2) begin
            check("t3_first_period", rd2_times[1] - rd2_times[0], 6);
        end else begin
            check("t3_first_period", 0, 6);
        end
        bad = 0;
        for (int i = 1; i < rd2_times.size(); i++) begin
            if (rd2_times[i] - rd2_times[i-1] != 6) bad++;
        end
        check("t3_bad_periods", bad, 0);
        check("t3_vec_count", cnt2, 100);
        check("t3_records", recs2, 100);
        check("t3_done_pulses", done_cnt2, 1);
        check("t3_sb_empty", sb2.size(), 0);

        // Abort during HOLD of vector 10 (DA=0, DB=5, DUT_CLK=0)
        push_run(1, 100);
        recs1 = 0; done_cnt1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (rd1 && addr1 == 7'd10) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t4_found_fetch10", found, 1);
        repeat (3) @(negedge clk);
        check("t4_hold_db", db1, 5);
        check("t4_hold_valid", val1, 0);
        abort1 = 1'b1;
        @(negedge clk);
        abort1 = 1'b0;
        check("t4_busy", busy1, 0);
        check("t4_cap_valid", val1, 0);
        check("t4_vec_count", cnt1, 10);
        check("t4_da", da1, 0);
        check("t4_db", db1, 5);
        check("t4_dut_clk", dclk1, 0);
        check("t4_records", recs1, 10);
        repeat (20) @(negedge clk);
        check("t4_no_done", done_cnt1, 0);
        check("t4_still_idle", busy1, 0);
        check("t4_db_kept", db1, 5);
        sb1.delete();

        // Reset while record 5 is waiting in CAPTURE
        push_run(1, 100);
        recs1 = 0;
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (val1 && idx1 == 7'd5) begin
                found = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check("t5_found_rec5", found, 1);
        rst_n = 1'b0;
        #2;
        check_zero1("t5");
        sb1.delete();
        @(negedge clk);
        rst_n = 1'b1;

        // start+abort together in IDLE starts a run; start while busy ignored
        push_run(1, 100);
        recs1 = 0; done_cnt1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        abort1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        abort1 = 1'b0;
        c0 = cyc;
        check("t6_rd_en", rd1, 1);
        check("t6_addr", addr1, 0);
        repeat (30) @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        check("t6_busy", busy1, 1);
        wait_done(1, 2000, dcyc);
        check("t6_done_at", dcyc - c0, 800);
        @(negedge clk);
        check("t6_vec_count", cnt1, 100);
        check("t6_records", recs1, 100);
        check("t6_done_pulses", done_cnt1, 1);
        check("t6_sb_empty", sb1.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sequencer.md
# vector_sequencer

Hardware replacement for the file-driven stimulus loop around `rtl_top`. It fetches packed stimulus words `{DA,DB,DUT_CLK}` from a synchronous pattern memory and applies each one to the DUT with programmable set-up and hold spacing. It samples `Q` after the hold window and streams `{DA,DB,DUT_CLK,Q}` records out over a valid/ready port, for on-chip logging or comparison. It sits between the pattern ROM/RAM and `rtl_top`, which it sequences exclusively.

## Interface
- `WIDTH`, 9: stimulus word width; bits [8:5] DA, [4:1] DB, [0] DUT_CLK.
- `DEPTH`, 100: number of vectors per run, 1..2^ADDR_W.
- `ADDR_W`, 7: pattern memory address width.
- `STEP1`, 1: cycles waited after the word is loaded before it is driven; ≥1.
- `STEP2`, 4: cycles between driving and sampling `Q`; ≥1.
- `CLK` in 1: single system clock, all logic rising-edge.
- `RST_N` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a run; sampled only in IDLE.
- `abort` in 1: synchronous stop of a run in progress.
- `busy` out 1: high from the cycle after accepted `start` until DONE exits.
- `done` out 1: one-cycle pulse after the last record is accepted.
- `mem_rd_en` out 1: memory read strobe.
- `mem_addr` out ADDR_W: read address, 0..DEPTH-1.
- `mem_rdata` in WIDTH: read data, valid the cycle after `mem_rd_en`.
- `DA`, `DB` out 4 each: DUT operands, registered.
- `DUT_CLK` out 1: DUT clock bit from the vector, registered.
- `Q` in 4: DUT result.
- `cap_valid` out 1: capture record valid.
- `cap_ready` in 1: consumer accepts the record.
- `cap_data` out 13: `{DA,DB,DUT_CLK,Q}` at sample time.
- `cap_index` out ADDR_W: vector index of the record.
- `vec_count` out ADDR_W+1: records accepted in the current or last run.

## Operation
- **States:** IDLE, FETCH, RDWAIT, SETUP, HOLD, CAPTURE, DONE.
- **IDLE:** on `start`, go to FETCH. Clear the index and `vec_count` to 0.
- **FETCH:** assert `mem_rd_en` for one cycle with `mem_addr`=index. Go to RDWAIT.
- **RDWAIT:** latch `mem_rdata` into the vector register. Load the timer with STEP1. Go to SETUP.
- **SETUP:** when the timer reaches 0, drive DA/DB/DUT_CLK from the vector register. Load the timer with STEP2. Go to HOLD.
- **HOLD:** when the timer reaches 0, register `cap_data`={DA,DB,DUT_CLK,Q} and `cap_index`=index. Raise `cap_valid`. Go to CAPTURE.
- **CAPTURE:** hold `cap_valid`, `cap_data` and `cap_index` stable until `cap_valid && cap_ready`. On transfer, increment `vec_count`. If index==DEPTH-1, go to DONE; otherwise increment the index and go to FETCH.
- **DONE:** pulse `done` for one cycle, then return to IDLE.
- `start` while busy is ignored.
- `abort` in any non-IDLE state:
  - go to IDLE next cycle and drop `cap_valid`;
  - no `done` pulse;
  - DA/DB/DUT_CLK hold their last driven values;
  - `vec_count` keeps the records transferred so far.
- `abort` and `start` high together in IDLE: `start` wins.
- **Reset** (`RST_N` low, any time including mid-run): state IDLE; all outputs 0; `mem_addr`=0; `vec_count`=0; vector register cleared.
- The index never wraps: DEPTH-1 is terminal.

## Timing
- Accepted `start` at edge t0 → `mem_rd_en` high in cycle t0..t1.
- `mem_rdata` is captured at t2.
- DUT outputs change at edge t2+STEP1.
- `Q` is sampled at edge t2+STEP1+STEP2; `cap_valid` is high from that edge.
- With `cap_ready` held high, the vector period is 3+STEP1+STEP2 cycles (8 at defaults). A full default run takes 800 cycles, plus 1 for DONE.
- Consumer stall extends CAPTURE cycle-for-cycle; no record is lost or duplicated.
- `busy` falls at the edge leaving DONE, coincident with `done` falling.

## Structure
- Package `vector_sequencer_pkg`:
  - state enum;
  - field offsets `DA_MSB`=8, `DA_LSB`=5, `DB_MSB`=4, `DB_LSB`=1, `CLK_BIT`=0;
  - capture record width constant 13.
- Sub-module `seq_step_timer`: loadable down-counter with a `zero` flag, shared by SETUP and HOLD.

## Test plan
- Defaults, `cap_ready`=1, memory holding vector i = i mod 512:
  - exactly 100 records;
  - `cap_index` 0..99 in order;
  - record k has DA/DB/DUT_CLK = k[8:5]/k[4:1]/k[0];
  - `done` pulses once at cycle 801 after `start`;
  - `vec_count`=100.
- `cap_ready` low for 5 cycles on record 3: `cap_data` stable throughout; next `mem_rd_en` follows the transfer edge by one cycle; total run length +5.
- STEP1=2, STEP2=1, DUT `Q`=DA^DB: each record's `Q` field equals DA^DB. Period 6 cycles, measured from `mem_rd_en` spacing.
- `abort` during HOLD of vector 10: IDLE next cycle; `cap_valid`=0; no `done`; `vec_count`=10; DA/DB unchanged.
- `RST_N` low mid-CAPTURE: all outputs 0 immediately; a subsequent `start` restarts from `mem_addr`=0.
- `start` pulsed while busy, and `start`+`abort` together in IDLE: the first is ignored; the second begins a run.
